// File: rtl/toggle_pkg.sv
// Shared types and default widths for the toggle burst controller.
package toggle_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } toggle_state_t;

    localparam int PERIOD_W_DEF = 16;
    localparam int COUNT_W_DEF  = 8;

endpackage

// File: rtl/tick_timer.sv
// Reloadable down-counter: tick is high while the count is zero, and the
// count reloads from the latched value on every enabled tick.
module tick_timer
    import toggle_pkg::*;
#(
    parameter int WIDTH = PERIOD_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             tick
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] timer_q, timer_d;
    logic [WIDTH-1:0] reload_q, reload_d;

    assign tick = (timer_q == '0);

    always_comb begin
        timer_d  = timer_q;
        reload_d = reload_q;
        if (load) begin
            timer_d  = load_val;
            reload_d = load_val;
        end else if (en) begin
            timer_d = tick ? reload_q : (timer_q - ONE);
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q  <= '0;
            reload_q <= '0;
        end else begin
            timer_q  <= timer_d;
            reload_q <= reload_d;
        end
    end

endmodule

// File: rtl/toggle_ctrl.sv
// Burst controller: accepts (period, count) commands and flips a registered
// square wave every period cycles, count times, with a matching strobe.
module toggle_ctrl
    import toggle_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DEF,
    parameter int COUNT_W  = COUNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic [COUNT_W-1:0]  cmd_count,
    input  logic                abort,
    output logic                cmd_ready,
    output logic                toggle_en,
    output logic                wave,
    output logic                busy,
    output logic                done
);

    localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
    localparam logic [COUNT_W-1:0]  C_ONE = COUNT_W'(1);

    toggle_state_t      state_q, state_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic               wave_q, wave_d;
    logic               done_q, done_d;

    logic                tick;
    logic                timer_load;
    logic                timer_en;
    logic [PERIOD_W-1:0] reload_val;

    // A zero period behaves exactly like a period of one.
    assign reload_val = (cmd_period == '0) ? '0 : (cmd_period - P_ONE);
    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign timer_load = cmd_ready && cmd_valid && (cmd_count != '0);
    assign timer_en   = busy && !abort;
    assign toggle_en  = busy && tick && !abort;
    assign wave       = wave_q;
    assign done       = done_q;

    tick_timer #(
        .WIDTH(PERIOD_W)
    ) u_tick_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .load_val(reload_val),
        .en      (timer_en),
        .tick    (tick)
    );

    // NOTE: defaults first so every path assigns every signal (no latches).
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wave_d      = wave_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = RUN;
                        remaining_d = cmd_count;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick) begin
                    wave_d      = ~wave_q;
                    remaining_d = remaining_q - C_ONE;
                    if (remaining_q == C_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            wave_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wave_q      <= wave_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_toggle_ctrl.sv
// Directed bench for toggle_ctrl: expected flip edges and done cycles are
// scheduled from the accept edge and compared as the DUT produces them.
module tb_toggle_ctrl;
    import toggle_pkg::*;

    localparam int PW = PERIOD_W_DEF;
    localparam int CW = COUNT_W_DEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [PW-1:0] cmd_period;
    logic [CW-1:0] cmd_count;
    logic          abort;
    logic          cmd_ready;
    logic          toggle_en;
    logic          wave;
    logic          busy;
    logic          done;

    toggle_ctrl #(
        .PERIOD_W(PW),
        .COUNT_W (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_period(cmd_period),
        .cmd_count (cmd_count),
        .abort     (abort),
        .cmd_ready (cmd_ready),
        .toggle_en (toggle_en),
        .wave      (wave),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   edge_no;
        logic lvl;
    } flip_t;

    flip_t flip_q[$];
    int    done_q[$];
    int    cyc        = 0;
    logic  model_wave = 1'b0;
    logic  lvl        = 1'b0;
    bit    mon_en     = 1'b0;
    int    checks     = 0;
    int    errors     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Outputs are sampled on the falling edge; the flip at edge cyc+1 is due now.
    always @(negedge clk) begin
        if (mon_en) begin
            check("wave_level", wave, model_wave);
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                check("done_pulse", done, 1);
                done_q.delete(0);
            end else begin
                check("done_quiet", done, 0);
            end
            if (flip_q.size() > 0 && flip_q[0].edge_no == cyc + 1) begin
                check("toggle_en_flip", toggle_en, 1);
                model_wave = flip_q[0].lvl;
                flip_q.delete(0);
            end else begin
                check("toggle_en_quiet", toggle_en, 0);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic schedule(input int k, input int p, input int flips, input bit with_done);
        int peff;
        peff = (p == 0) ? 1 : p;
        for (int i = 1; i <= flips; i++) begin
            lvl = ~lvl;
            flip_q.push_back('{edge_no: k + i * peff, lvl: lvl});
        end
        if (with_done) done_q.push_back(k + flips * peff);
    endtask

    task automatic issue(input int p, input int n);
        cmd_valid  = 1'b1;
        cmd_period = PW'(p);
        cmd_count  = CW'(n);
        schedule(cyc + 1, p, n, 1'b1);
        next_cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((flip_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            next_cycle();
            n++;
        end
        check(tag, (flip_q.size() == 0 && done_q.size() == 0), 1);
    endtask

    initial begin
        int k;
        int k2;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_period = '0;
        cmd_count  = '0;
        abort      = 1'b0;
        repeat (2) next_cycle();
        reset  = 1'b0;
        mon_en = 1'b1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_wave", wave, 0);
        check("rst_done", done, 0);
        repeat (20) next_cycle();

        // P=3, N=4: flips at k+3, k+6, k+9, k+12
        issue(3, 4);
        check("p3_busy", busy, 1);
        check("p3_ready_low", cmd_ready, 0);
        wait_idle("p3_drain", 40);
        check("p3_wave_end", wave, 0);
        check("p3_ready_end", cmd_ready, 1);

        // P=0 acts as P=1: three back-to-back flips
        issue(0, 3);
        wait_idle("p0_drain", 20);
        check("p0_wave_end", wave, 1);

        // N=0: done only, no flip
        issue(5, 0);
        check("n0_busy", busy, 0);
        wait_idle("n0_drain", 5);
        check("n0_wave", wave, 1);

        issue(1, 1);
        wait_idle("p1_drain", 5);
        check("p1_wave", wave, 0);

        // Abort on the third tick, with a command already waiting
        k = cyc + 1;
        cmd_valid  = 1'b1;
        cmd_period = PW'(4);
        cmd_count  = CW'(10);
        schedule(k, 4, 2, 1'b0);
        next_cycle();
        cmd_valid = 1'b0;
        repeat (2) next_cycle();
        cmd_valid  = 1'b1;
        cmd_period = PW'(2);
        cmd_count  = CW'(5);
        repeat (3) next_cycle();
        check("held_not_ready", cmd_ready, 0);
        check("held_busy", busy, 1);
        while (cyc < k + 11) next_cycle();
        abort = 1'b1;
        #1;
        check("abort_beats_tick", toggle_en, 0);
        next_cycle();
        abort = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_wave", wave, 0);
        k2 = cyc + 1;
        schedule(k2, 2, 3, 1'b0);
        next_cycle();
        cmd_valid = 1'b0;
        check("held_accepted", busy, 1);

        // Reset mid-burst after three flips
        while (cyc < k2 + 6) next_cycle();
        check("pre_reset_wave", wave, 1);
        reset = 1'b1;
        next_cycle();
        reset      = 1'b0;
        model_wave = 1'b0;
        lvl        = 1'b0;
        check("reset_wave", wave, 0);
        check("reset_idle", busy, 0);
        check("reset_ready", cmd_ready, 1);
        repeat (2) next_cycle();

        issue(1, 1);
        wait_idle("fresh_drain", 5);
        check("fresh_wave", wave, 1);
        repeat (3) next_cycle();

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
